// File: rtl/morph_pkg.sv
// Shared constants for the 3x3 morphology blocks (erosion and dilation).
package morph_pkg;
  localparam int   MORPH_DATA_W = 10;
  localparam int   ROW_W        = 12;
  localparam int   ROW_MAX      = 4095;
  localparam logic PAD_BIT      = 1'b1;
endpackage

// File: rtl/morph_linebuf.sv
// Dual-tap line store: returns the same-column pixel from one and two lines back.
module morph_linebuf #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 10,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tap1,
  output logic [DATA_W-1:0] tap2
);

  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];

  assign tap1 = mem1[addr];
  assign tap2 = mem2[addr];

  // Cascading mem1 into mem2 at the same address ages each column by one line.
  always_ff @(posedge clk) begin
    if (en) begin
      mem1[addr] <= din;
      mem2[addr] <= mem1[addr];
    end
  end

endmodule

// File: rtl/morph_erode_3x3.sv
// 3x3 grayscale erosion (window minimum) over a raster stream, stall-transparent input side.
module morph_erode_3x3
  import morph_pkg::*;
#(
  parameter int IMG_WIDTH = 640,
  parameter int DATA_W    = MORPH_DATA_W
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic [DATA_W-1:0] input_data,
  output logic              oDVAL,
  output logic [DATA_W-1:0] output_data
);

  localparam int                AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [DATA_W-1:0] PAD      = {DATA_W{PAD_BIT}};
  localparam logic [AW-1:0]     COL_LAST = AW'(IMG_WIDTH - 1);

  function automatic logic [DATA_W-1:0] min2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  logic [AW-1:0]     col;
  logic [ROW_W-1:0]  row;
  logic [AW-1:0]     cur_col;
  logic [ROW_W-1:0]  cur_row;
  logic [DATA_W-1:0] tap_r1;
  logic [DATA_W-1:0] tap_r2;

  assign cur_col = iSOF ? '0 : col;
  assign cur_row = iSOF ? '0 : row;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      col <= '0;
      row <= '0;
    end else if (iDVAL) begin
      if (cur_col == COL_LAST) begin
        col <= '0;
        row <= (cur_row == ROW_W'(ROW_MAX)) ? cur_row : cur_row + ROW_W'(1);
      end else begin
        col <= cur_col + AW'(1);
        row <= cur_row;
      end
    end
  end

  morph_linebuf #(
    .DEPTH  (IMG_WIDTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_linebuf (
    .clk  (CLOCK),
    .en   (iDVAL),
    .addr (cur_col),
    .din  (input_data),
    .tap1 (tap_r1),
    .tap2 (tap_r2)
  );

  // Stage 1: window shift; row 0 = line r-2, column 0 = oldest column c-2.
  logic [DATA_W-1:0] win_p1 [3][3];
  logic              vld_p1;
  logic              top_p1;
  logic              left_p1;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win_p1[i][j] <= '0;
      vld_p1  <= 1'b0;
      top_p1  <= 1'b0;
      left_p1 <= 1'b0;
    end else begin
      vld_p1 <= iDVAL && (cur_row != '0) && (cur_col != '0);
      if (iDVAL) begin
        for (int i = 0; i < 3; i++) begin
          win_p1[i][0] <= win_p1[i][1];
          win_p1[i][1] <= win_p1[i][2];
        end
        win_p1[0][2] <= tap_r2;
        win_p1[1][2] <= tap_r1;
        win_p1[2][2] <= input_data;
        // Row 1 of a frame has no valid line r-2 (border or stale previous frame).
        top_p1  <= (cur_row == ROW_W'(1));
        left_p1 <= (cur_col == AW'(1));
      end
    end
  end

  logic [DATA_W-1:0] win_min;
  logic [DATA_W-1:0] tap_val;

  always_comb begin
    win_min = PAD;
    tap_val = PAD;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        tap_val = ((i == 0 && top_p1) || (j == 0 && left_p1)) ? PAD : win_p1[i][j];
        win_min = min2(win_min, tap_val);
      end
    end
  end

  // Stage 2: registered minimum, forced to zero when not valid.
  logic              vld_p2;
  logic [DATA_W-1:0] data_p2;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      vld_p2  <= 1'b0;
      data_p2 <= '0;
    end else begin
      vld_p2  <= vld_p1;
      data_p2 <= vld_p1 ? win_min : '0;
    end
  end

  assign oDVAL       = vld_p2;
  assign output_data = data_p2;

endmodule
